// File: rtl/add_round_key_pipe.sv
// Pipelined AddRoundKey: a round-key store plus a global-stall pipeline that XORs
// each accepted state block with the key selected by its round index.
module add_round_key_pipe #(
    parameter  int DATA_WIDTH = 128,
    parameter  int NUM_KEYS   = 15,
    parameter  int LATENCY    = 2,
    localparam int IDX_WIDTH  = $clog2(NUM_KEYS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  key_we,
    input  logic [IDX_WIDTH-1:0]  key_idx,
    input  logic [DATA_WIDTH-1:0] key_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [IDX_WIDTH-1:0]  in_round,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_round,
    output logic                  out_err
);

    typedef struct packed {
        logic                  err;
        logic [IDX_WIDTH-1:0]  round;
        logic [DATA_WIDTH-1:0] data;
    } blk_t;

    logic [NUM_KEYS-1:0][DATA_WIDTH-1:0] key_q;
    logic [NUM_KEYS-1:0]                 key_vld_q;
    logic [LATENCY:1]                    vld_pipe_q;
    blk_t [LATENCY:1]                    blk_q;
    blk_t                                blk_d;
    logic [DATA_WIDTH-1:0]               key_sel;
    logic                                key_hit;
    logic                                stall;

    assign stall    = vld_pipe_q[LATENCY] && !out_ready;
    assign in_ready = !stall;

    // Out-of-range indices match no entry, so they fall out as a miss.
    always_comb begin
        key_sel = '0;
        key_hit = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (in_round == IDX_WIDTH'(k)) begin
                key_sel = key_q[k];
                key_hit = key_vld_q[k];
            end
        end
    end

    always_comb begin
        blk_d.err   = !key_hit;
        blk_d.round = in_round;
        blk_d.data  = key_hit ? (in_data ^ key_sel) : in_data;
    end

    // Key contents survive reset; only the valid bitmap is cleared.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_we && key_idx == IDX_WIDTH'(k)) begin
                key_q[k] <= key_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            key_vld_q <= '0;
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (key_we && key_idx == IDX_WIDTH'(k)) begin
                    key_vld_q[k] <= 1'b1;
                end
            end
        end
    end

    // Global stall: every stage holds together; data regs only load behind a valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_pipe_q <= '0;
            blk_q      <= '0;
        end else if (!stall) begin
            vld_pipe_q[1] <= in_valid;
            if (in_valid) begin
                blk_q[1] <= blk_d;
            end
            for (int s = 2; s <= LATENCY; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                if (vld_pipe_q[s-1]) begin
                    blk_q[s] <= blk_q[s-1];
                end
            end
        end
    end

    assign out_valid = vld_pipe_q[LATENCY];
    assign out_data  = blk_q[LATENCY].data;
    assign out_round = blk_q[LATENCY].round;
    assign out_err   = blk_q[LATENCY].err;

endmodule

// File: tb/tb_add_round_key_pipe.sv
// Directed bench for add_round_key_pipe: driver pushes expected blocks into a
// queue, an independent monitor pops and compares whatever the DUT presents.
module tb_add_round_key_pipe;

    localparam int DW  = 128;
    localparam int NK  = 15;
    localparam int LAT = 2;
    localparam int IW  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          key_we = 1'b0;
    logic [IW-1:0] key_idx = '0;
    logic [DW-1:0] key_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] in_round = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_round;
    logic          out_err;

    add_round_key_pipe #(.DATA_WIDTH(DW), .NUM_KEYS(NK), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .key_we(key_we), .key_idx(key_idx), .key_data(key_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_round(in_round),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_round(out_round), .out_err(out_err)
    );

    always #5 clock = ~clock;

    // FIPS-197 appendix C.1 key schedule, rounds 0..10
    logic [DW-1:0] ks [0:10] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6f,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };
    localparam logic [DW-1:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] ARK0   = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [DW-1:0] MCOL1  = 128'h5f72641557f5bc92f7be3b291db9f91a;
    localparam logic [DW-1:0] START2 = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [DW-1:0] NEWK   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [DW-1:0] ONES   = '1;

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] round;
        logic          err;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   pop_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   waits = 0;
    bit   lat_chk = 1'b1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output data=%h round=%0d err=%0b", out_data, out_round, out_err);
            end else begin
                mon_e = exp_q[0];
                chk("out_data", out_data, mon_e.data);
                chk("out_round", DW'(out_round), DW'(mon_e.round));
                chk("out_err", DW'(out_err), DW'(mon_e.err));
                if (out_ready) begin
                    if (mon_e.lat) chk("latency", DW'(cyc - mon_e.acc), DW'(LAT));
                    pop_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [IW-1:0] r,
                        input logic [DW-1:0] ed, input logic ee);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        in_data  = d;
        in_round = r;
        @(negedge clock);
        n = 0;
        while (!in_ready && n < 50) begin
            waits++;
            n++;
            @(negedge clock);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=in_ready_low required=accepted round=%0d", r);
        end else begin
            e.data = ed; e.round = r; e.err = ee; e.acc = cyc; e.lat = lat_chk;
            exp_q.push_back(e);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wkey(input logic [IW-1:0] i, input logic [DW-1:0] d);
        key_we = 1'b1; key_idx = i; key_data = d;
        @(posedge clock); #1;
        key_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_round", DW'(out_round), '0);
        chk("rst_out_err", DW'(out_err), '0);
        chk("rst_in_ready", DW'(in_ready), DW'(1));
        @(posedge clock); #1;

        // FIPS round 0, then error paths
        wkey(4'd0, ks[0]);
        send(PT, 4'd0, ARK0, 1'b0);
        send(128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 4'd5, 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a, 1'b1);
        wkey(4'd15, NEWK);
        send(128'hdeadbeef0123456789abcdeffedcba98, 4'd15, 128'hdeadbeef0123456789abcdeffedcba98, 1'b1);
        send('0, 4'd0, ks[0], 1'b0);
        drain();

        // back-to-back, 11 rounds
        for (int r = 1; r <= 10; r++) wkey(IW'(r), ks[r]);
        waits = 0;
        pop_cyc.delete();
        send(PT, 4'd0, ARK0, 1'b0);
        send(MCOL1, 4'd1, START2, 1'b0);
        for (int r = 2; r <= 10; r++) send('0, IW'(r), ks[r], 1'b0);
        drain();
        chk("b2b_in_ready_waits", DW'(waits), '0);
        chk("b2b_count", DW'(pop_cyc.size()), DW'(11));
        if (pop_cyc.size() == 11) chk("b2b_consecutive", DW'(pop_cyc[10] - pop_cyc[0]), DW'(10));

        // backpressure
        lat_chk = 1'b0;
        out_ready = 1'b0;
        pop_cyc.delete();
        fork
            begin
                for (int r = 4; r <= 7; r++) send(ONES, IW'(r), ~ks[r], 1'b0);
            end
            begin
                int n = 0;
                while (!out_valid && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                chk("bp_first_valid", DW'(out_valid), DW'(1));
                for (int i = 0; i < 5; i++) begin
                    chk("bp_in_ready", DW'(in_ready), '0);
                    if (i < 4) @(negedge clock);
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;
        chk("bp_count", DW'(pop_cyc.size()), DW'(4));

        // key hazard: same-edge write uses old key
        key_we = 1'b1; key_idx = 4'd3; key_data = NEWK;
        send('0, 4'd3, ks[3], 1'b0);
        key_we = 1'b0;
        send('0, 4'd3, NEWK, 1'b0);
        drain();

        // reset mid-stream
        send('0, 4'd1, ks[1], 1'b0);
        send('0, 4'd2, ks[2], 1'b0);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_out_valid", DW'(out_valid), '0);
        @(posedge clock); #1;
        send(128'h0123456789abcdef0123456789abcdef, 4'd0, 128'h0123456789abcdef0123456789abcdef, 1'b1);
        drain();
        wkey(4'd0, ks[0]);
        send(PT, 4'd0, ARK0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
